// File: rtl/memory_slave_ctrl_pkg.sv
// rtl/memory_slave_ctrl_pkg.sv - shared types, defaults and helpers for the memory slave
// Purpose: FSM state type, default parameter values and the address range check
//          used by both the controller and the storage array.
// Ports:   none (package).
package memory_slave_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_SIZE   = 16;
  localparam int DEF_RD_LATENCY = 1;

  // Unsigned compare; the caller zero-extends its address to 32 bits.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_size);
    return (addr < mem_size);
  endfunction

endpackage

// File: rtl/memory_slave_ctrl_if.sv
// rtl/memory_slave_ctrl_if.sv - request/response bus between master and memory slave
// Purpose: groups the request (wr/rd/addr/wdata/be) and response
//          (rdata/slv_rsp/slv_err/busy) signals.
// Modports: master drives requests and observes responses; slave is the reverse.
interface memory_slave_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic                    wr;
  logic                    rd;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    slv_rsp;
  logic                    slv_err;
  logic                    busy;

  modport master (
    output wr, rd, addr, wdata, be,
    input  rdata, slv_rsp, slv_err, busy
  );

  modport slave (
    input  wr, rd, addr, wdata, be,
    output rdata, slv_rsp, slv_err, busy
  );

endinterface

// File: rtl/memory_slave_ctrl_array.sv
// rtl/memory_slave_ctrl_array.sv - MEM_SIZE x DATA_WIDTH storage with byte-enable write
// Purpose: register-file storage, cleared by async reset; byte-enable write
//          port and a registered read port.
// Ports:   clk, rst_n (async active-low), we_i/waddr_i/wdata_i/be_i write port,
//          re_i/raddr_i read request, rdata_o registered read result.
module memory_slave_ctrl_array
  import memory_slave_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;
  logic                  rd_in_range;

  assign widx        = waddr_i[IDX_W-1:0];
  assign ridx        = raddr_i[IDX_W-1:0];
  assign rd_in_range = addr_ok(32'(raddr_i), MEM_SIZE);
  assign rdata_o     = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < MEM_SIZE; w++) begin
        mem_q[w] <= '0;
      end
      rdata_q <= '0;
    end else begin
      // The controller only asserts we_i for in-range addresses.
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) begin
            mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
      // Addresses without storage read as zero.
      if (re_i) begin
        rdata_q <= rd_in_range ? mem_q[ridx] : '0;
      end
    end
  end

endmodule

// File: rtl/memory_slave_ctrl.sv
// rtl/memory_slave_ctrl.sv - memory slave: FSM, read latency, range check, responses
// Purpose: accepts single write/read requests, checks the address range,
//          applies RD_LATENCY to reads and issues a one-cycle slv_rsp/slv_err.
// Ports:   clk, reset (async active-low), bus (slave modport: wr, rd, addr,
//          wdata, be in; rdata, slv_rsp, slv_err, busy out).
module memory_slave_ctrl
  import memory_slave_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_slave_ctrl_if.slave   bus
);

  localparam int CNT_W = 3;

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_chk_lat
    $error("RD_LATENCY must be in 1..8");
  end
  if (MEM_SIZE < 1 || MEM_SIZE > 2**ADDR_WIDTH) begin : g_chk_size
    $error("MEM_SIZE must be in 1..2**ADDR_WIDTH");
  end

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  rsp_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  pend_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  in_range;
  logic                  wr_req;
  logic                  rd_req;
  logic                  both_req;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign in_range = addr_ok(32'(bus.addr), MEM_SIZE);
  assign wr_req   = (state_q == IDLE) && bus.wr && !bus.rd;
  assign rd_req   = (state_q == IDLE) && bus.rd && !bus.wr;
  assign both_req = (state_q == IDLE) && bus.wr && bus.rd;

  // The array captures read data at the sample edge, so a pending read is
  // unaffected by anything that happens during RD_WAIT.
  memory_slave_ctrl_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (wr_req && in_range),
    .waddr_i (bus.addr),
    .wdata_i (bus.wdata),
    .be_i    (bus.be),
    .re_i    (rd_req),
    .raddr_i (bus.addr),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      pend_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rsp_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            rsp_q <= 1'b1;
            err_q <= !in_range;
          end else if (rd_req) begin
            if (RD_LATENCY == 1) begin
              rsp_q <= 1'b1;
              err_q <= !in_range;
            end else begin
              state_q    <= RD_WAIT;
              cnt_q      <= CNT_W'(RD_LATENCY - 2);
              busy_q     <= 1'b1;
              pend_err_q <= !in_range;
            end
          end else if (both_req) begin
            rsp_q <= 1'b1;
            err_q <= 1'b1;
          end
        end
        RD_WAIT: begin
          // Requests during RD_WAIT, including on the exit edge, are dropped.
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rsp_q   <= 1'b1;
            err_q   <= pend_err_q;
            rdata_q <= arr_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // With single-cycle latency the array's read register is the result itself.
  assign bus.rdata   = (RD_LATENCY == 1) ? arr_rdata : rdata_q;
  assign bus.slv_rsp = rsp_q;
  assign bus.slv_err = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_memory_slave_ctrl.sv
// tb/tb_memory_slave_ctrl.sv - directed self-checking bench for memory_slave_ctrl
module tb_memory_slave_ctrl;

  logic clk;
  logic rst_ab;
  logic rst_c;
  int   checks;
  int   passed;

  // A: 16 words, latency 1.  B: 12 words, latency 3.  C: 16 words, latency 4.
  memory_slave_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_a ();
  memory_slave_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_b ();
  memory_slave_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_c ();

  memory_slave_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16), .RD_LATENCY(1))
    dut_a (.clk(clk), .reset(rst_ab), .bus(bus_a));
  memory_slave_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(12), .RD_LATENCY(3))
    dut_b (.clk(clk), .reset(rst_ab), .bus(bus_b));
  memory_slave_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16), .RD_LATENCY(4))
    dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic a_drive(input logic w, input logic r, input logic [3:0] ad,
                         input logic [31:0] d, input logic [3:0] e);
    bus_a.wr = w; bus_a.rd = r; bus_a.addr = ad; bus_a.wdata = d; bus_a.be = e;
  endtask

  task automatic b_drive(input logic w, input logic r, input logic [3:0] ad,
                         input logic [31:0] d, input logic [3:0] e);
    bus_b.wr = w; bus_b.rd = r; bus_b.addr = ad; bus_b.wdata = d; bus_b.be = e;
  endtask

  task automatic c_drive(input logic w, input logic r, input logic [3:0] ad,
                         input logic [31:0] d, input logic [3:0] e);
    bus_c.wr = w; bus_c.rd = r; bus_c.addr = ad; bus_c.wdata = d; bus_c.be = e;
  endtask

  // Returns the cycle (1 = first cycle after the sample edge) carrying slv_rsp, or -1.
  task automatic b_wait(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) b_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
      if (bus_b.slv_rsp) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic c_wait(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) c_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
      if (bus_c.slv_rsp) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    a_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    b_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    c_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.rdata, bus_a.slv_rsp, bus_a.slv_err, bus_a.busy} !== 35'd0)
      $display("FAIL reset_a: rdata=%h rsp=%b err=%b busy=%b, want all 0",
               bus_a.rdata, bus_a.slv_rsp, bus_a.slv_err, bus_a.busy);
    else passed++;
    checks++;
    if ({bus_b.rdata, bus_b.slv_rsp, bus_b.slv_err, bus_b.busy} !== 35'd0)
      $display("FAIL reset_b: rdata=%h rsp=%b err=%b busy=%b, want all 0",
               bus_b.rdata, bus_b.slv_rsp, bus_b.slv_err, bus_b.busy);
    else passed++;
    checks++;
    if ({bus_c.rdata, bus_c.slv_rsp, bus_c.slv_err, bus_c.busy} !== 35'd0)
      $display("FAIL reset_c: rdata=%h rsp=%b err=%b busy=%b, want all 0",
               bus_c.rdata, bus_c.slv_rsp, bus_c.slv_err, bus_c.busy);
    else passed++;
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      a_drive(1'b0, 1'b1, 4'(i), 32'd0, 4'd0);
      @(negedge clk);
      if (bus_a.slv_rsp !== 1'b1 || bus_a.slv_err !== 1'b0 || bus_a.rdata !== 32'd0) bad++;
    end
    a_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    checks++;
    if (bad !== 0) $display("FAIL reset_read_all: %0d bad reads, want 0", bad);
    else passed++;
  endtask

  task automatic test_byte_enable();
    a_drive(1'b1, 1'b0, 4'd3, 32'hAABBCCDD, 4'hF);
    @(negedge clk);
    checks++;
    if (bus_a.slv_rsp !== 1'b1 || bus_a.slv_err !== 1'b0)
      $display("FAIL be_wr_full: rsp=%b err=%b, want 1/0", bus_a.slv_rsp, bus_a.slv_err);
    else passed++;
    a_drive(1'b1, 1'b0, 4'd3, 32'h11223344, 4'h5);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 4'd3, 32'hFFFFFFFF, 4'h0);
    @(negedge clk);
    checks++;
    if (bus_a.slv_rsp !== 1'b1 || bus_a.slv_err !== 1'b0)
      $display("FAIL be_zero_rsp: rsp=%b err=%b, want 1/0", bus_a.slv_rsp, bus_a.slv_err);
    else passed++;
    a_drive(1'b0, 1'b1, 4'd3, 32'd0, 4'd0);
    @(negedge clk);
    checks++;
    if (bus_a.rdata !== 32'hAA22CC44 || bus_a.slv_err !== 1'b0 || bus_a.slv_rsp !== 1'b1)
      $display("FAIL be_readback: rdata=%h err=%b rsp=%b, want aa22cc44/0/1",
               bus_a.rdata, bus_a.slv_err, bus_a.slv_rsp);
    else passed++;
    a_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    @(negedge clk);
    checks++;
    if (bus_a.slv_rsp !== 1'b0 || bus_a.slv_err !== 1'b0)
      $display("FAIL be_rsp_pulse: rsp=%b err=%b, want 0/0", bus_a.slv_rsp, bus_a.slv_err);
    else passed++;
  endtask

  task automatic test_latency();
    int cyc;
    b_drive(1'b1, 1'b0, 4'd3, 32'h12345678, 4'hF);
    @(negedge clk);
    checks++;
    if (bus_b.slv_rsp !== 1'b1 || bus_b.slv_err !== 1'b0 || bus_b.busy !== 1'b0)
      $display("FAIL lat_wr: rsp=%b err=%b busy=%b, want 1/0/0",
               bus_b.slv_rsp, bus_b.slv_err, bus_b.busy);
    else passed++;
    b_drive(1'b0, 1'b1, 4'd3, 32'd0, 4'd0);
    @(negedge clk);
    checks++;
    if (bus_b.busy !== 1'b1 || bus_b.slv_rsp !== 1'b0 || bus_b.rdata !== 32'd0)
      $display("FAIL lat_n1: busy=%b rsp=%b rdata=%h, want 1/0/0",
               bus_b.busy, bus_b.slv_rsp, bus_b.rdata);
    else passed++;
    // Write held across both wait edges, including the one returning to IDLE.
    b_drive(1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checks++;
    if (bus_b.busy !== 1'b1 || bus_b.slv_rsp !== 1'b0)
      $display("FAIL lat_n2: busy=%b rsp=%b, want 1/0", bus_b.busy, bus_b.slv_rsp);
    else passed++;
    @(negedge clk);
    b_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    checks++;
    if (bus_b.slv_rsp !== 1'b1 || bus_b.slv_err !== 1'b0 || bus_b.busy !== 1'b0 ||
        bus_b.rdata !== 32'h12345678)
      $display("FAIL lat_n3: rsp=%b err=%b busy=%b rdata=%h, want 1/0/0/12345678",
               bus_b.slv_rsp, bus_b.slv_err, bus_b.busy, bus_b.rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus_b.slv_rsp !== 1'b0 || bus_b.slv_err !== 1'b0)
      $display("FAIL lat_ignored_wr: rsp=%b err=%b, want 0/0", bus_b.slv_rsp, bus_b.slv_err);
    else passed++;
    b_drive(1'b0, 1'b1, 4'd3, 32'd0, 4'd0);
    b_wait(cyc);
    checks++;
    if (cyc !== 3 || bus_b.rdata !== 32'h12345678)
      $display("FAIL lat_mem_unchanged: cycle=%0d rdata=%h, want 3/12345678", cyc, bus_b.rdata);
    else passed++;
  endtask

  task automatic test_errors();
    int cyc;
    b_drive(1'b1, 1'b0, 4'd13, 32'h99999999, 4'hF);
    @(negedge clk);
    b_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    checks++;
    if (bus_b.slv_rsp !== 1'b1 || bus_b.slv_err !== 1'b1)
      $display("FAIL err_wr13: rsp=%b err=%b, want 1/1", bus_b.slv_rsp, bus_b.slv_err);
    else passed++;
    b_drive(0, 1, 4'd15, 32'd0, 4'd0);
    b_wait(cyc);
    checks++;
    if (cyc !== 3 || bus_b.rdata !== 32'd0 || bus_b.slv_err !== 1'b1)
      $display("FAIL err_rd15: cycle=%0d rdata=%h err=%b, want 3/0/1",
               cyc, bus_b.rdata, bus_b.slv_err);
    else passed++;
    b_drive(1'b1, 1'b0, 4'd11, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    b_drive(1'b0, 1'b1, 4'd11, 32'd0, 4'd0);
    b_wait(cyc);
    checks++;
    if (cyc !== 3 || bus_b.rdata !== 32'hCAFEF00D || bus_b.slv_err !== 1'b0)
      $display("FAIL err_last_legal: cycle=%0d rdata=%h err=%b, want 3/cafef00d/0",
               cyc, bus_b.rdata, bus_b.slv_err);
    else passed++;
    b_drive(1'b1, 1'b0, 4'd12, 32'h12121212, 4'hF);
    @(negedge clk);
    checks++;
    if (bus_b.slv_rsp !== 1'b1 || bus_b.slv_err !== 1'b1)
      $display("FAIL err_wr12: rsp=%b err=%b, want 1/1", bus_b.slv_rsp, bus_b.slv_err);
    else passed++;
    b_drive(1'b1, 1'b1, 4'd3, 32'h55555555, 4'hF);
    @(negedge clk);
    b_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    checks++;
    if (bus_b.slv_rsp !== 1'b1 || bus_b.slv_err !== 1'b1 || bus_b.busy !== 1'b0 ||
        bus_b.rdata !== 32'hCAFEF00D)
      $display("FAIL err_wr_rd: rsp=%b err=%b busy=%b rdata=%h, want 1/1/0/cafef00d",
               bus_b.slv_rsp, bus_b.slv_err, bus_b.busy, bus_b.rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus_b.slv_rsp !== 1'b0 || bus_b.slv_err !== 1'b0)
      $display("FAIL err_pulse: rsp=%b err=%b, want 0/0", bus_b.slv_rsp, bus_b.slv_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  addrs [5] = '{4'd5, 4'd3, 4'd5, 4'd0, 4'd3};
    logic [31:0] exps  [5] = '{32'h000000FF, 32'hAA22CC44, 32'h000000FF, 32'h0, 32'hAA22CC44};
    a_drive(1'b1, 1'b0, 4'd5, 32'h000000FF, 4'hF);
    @(negedge clk);
    checks++;
    if (bus_a.slv_rsp !== 1'b1 || bus_a.slv_err !== 1'b0)
      $display("FAIL b2b_wr: rsp=%b err=%b, want 1/0", bus_a.slv_rsp, bus_a.slv_err);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      a_drive(1'b0, 1'b1, addrs[i], 32'd0, 4'd0);
      @(negedge clk);
      checks++;
      if (bus_a.slv_rsp !== 1'b1 || bus_a.slv_err !== 1'b0 || bus_a.rdata !== exps[i])
        $display("FAIL b2b_rd%0d: rsp=%b err=%b rdata=%h, want 1/0/%h",
                 i, bus_a.slv_rsp, bus_a.slv_err, bus_a.rdata, exps[i]);
      else passed++;
    end
    a_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    int spurious;
    c_drive(1'b1, 1'b0, 4'd7, 32'h77777777, 4'hF);
    @(negedge clk);
    c_drive(1'b0, 1'b1, 4'd7, 32'd0, 4'd0);
    c_wait(cyc);
    checks++;
    if (cyc !== 4 || bus_c.rdata !== 32'h77777777)
      $display("FAIL rmr_pre_read: cycle=%0d rdata=%h, want 4/77777777", cyc, bus_c.rdata);
    else passed++;
    c_drive(1'b0, 1'b1, 4'd7, 32'd0, 4'd0);
    @(negedge clk);
    c_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    checks++;
    if (bus_c.busy !== 1'b0 || bus_c.rdata !== 32'd0 || bus_c.slv_rsp !== 1'b0)
      $display("FAIL rmr_in_reset: busy=%b rdata=%h rsp=%b, want 0/0/0",
               bus_c.busy, bus_c.rdata, bus_c.slv_rsp);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    c_drive(1'b1, 1'b0, 4'd2, 32'h0F0F0F0F, 4'hF);
    @(negedge clk);
    c_drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    checks++;
    if (bus_c.slv_rsp !== 1'b1 || bus_c.slv_err !== 1'b0 || bus_c.busy !== 1'b0)
      $display("FAIL rmr_first_req: rsp=%b err=%b busy=%b, want 1/0/0",
               bus_c.slv_rsp, bus_c.slv_err, bus_c.busy);
    else passed++;
    spurious = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_c.slv_rsp !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) $display("FAIL rmr_no_stale_rsp: %0d responses, want 0", spurious);
    else passed++;
    c_drive(1'b0, 1'b1, 4'd7, 32'd0, 4'd0);
    c_wait(cyc);
    checks++;
    if (cyc !== 4 || bus_c.rdata !== 32'd0)
      $display("FAIL rmr_cleared: cycle=%0d rdata=%h, want 4/0", cyc, bus_c.rdata);
    else passed++;
    c_drive(1'b0, 1'b1, 4'd2, 32'd0, 4'd0);
    c_wait(cyc);
    checks++;
    if (cyc !== 4 || bus_c.rdata !== 32'h0F0F0F0F)
      $display("FAIL rmr_new_data: cycle=%0d rdata=%h, want 4/0f0f0f0f", cyc, bus_c.rdata);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    test_reset();
    test_byte_enable();
    test_latency();
    test_errors();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
